// File: rtl/car_sequencer.sv
// car_sequencer
//   Latches an MSP430 instruction word and steps the control address register
//   through its microsequence: FETCH -> [SRC_EXT] -> [DST_EXT] -> EXEC -> [WB],
//   with an IRQ_PC -> IRQ_SR -> IRQ_VEC entry sequence inserted between
//   instructions. Memory steps stall on MEM_rdy and are aborted by a watchdog
//   after MEM_WAIT_MAX stalled cycles.
//
// Ports
//   MCLK      in   system clock, rising edge
//   RST_n     in   asynchronous active-low reset
//   IW        in   instruction word from the fetch unit
//   IW_valid  in   IW is valid
//   IW_ack    out  IW latched this cycle (only ever in FETCH)
//   MEM_rdy   in   current memory step completes this cycle
//   IRQ       in   level interrupt request (sampled in FETCH only)
//   CAR       out  registered control address {class, step}
//   BUSY      out  step is not FETCH
//   ILLEGAL   out  high for the single EXEC cycle of an illegal opcode
//   TIMEOUT   out  high for the FETCH cycle following a watchdog abort
module car_sequencer #(
    parameter int CAR_BITS     = 6,
    parameter bit IRQ_EN       = 1'b1,
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic                MCLK,
    input  logic                RST_n,
    input  logic [15:0]         IW,
    input  logic                IW_valid,
    output logic                IW_ack,
    input  logic                MEM_rdy,
    input  logic                IRQ,
    output logic [CAR_BITS-1:0] CAR,
    output logic                BUSY,
    output logic                ILLEGAL,
    output logic                TIMEOUT
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_SRC_EXT = 3'd1,
        ST_DST_EXT = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WB      = 3'd4,
        ST_IRQ_PC  = 3'd5,
        ST_IRQ_SR  = 3'd6,
        ST_IRQ_VEC = 3'd7
    } step_e;

    localparam logic [2:0] CLS_FETCH   = 3'd0;
    localparam logic [2:0] CLS_ONEOP   = 3'd1;
    localparam logic [2:0] CLS_JUMP    = 3'd2;
    localparam logic [2:0] CLS_TWOOP   = 3'd3;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    // Watchdog aborts on the stalled cycle that would bring the count to the limit.
    localparam logic [7:0] WD_LAST = 8'(MEM_WAIT_MAX - 1);

    typedef struct packed {
        logic [2:0] cls;
        logic       src_ext;
        logic       dst_ext;
        logic       wb;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] w);
        dec_t       d;
        logic [1:0] as_m;
        logic [3:0] rs;
        d    = '0;
        as_m = w[5:4];
        if (w[15:13] == 3'b001) begin
            d.cls = CLS_JUMP;
        end else if (w[15:12] >= 4'd4) begin
            d.cls = CLS_TWOOP;
        end else if (w[15:10] == 6'b000100 && w[9:7] != 3'b111) begin
            d.cls = CLS_ONEOP;
        end else begin
            d.cls = CLS_ILLEGAL;
        end
        rs = (d.cls == CLS_TWOOP) ? w[11:8] : w[3:0];
        // Indexed (As=01, not the R3 constant generator) and immediate (@PC+)
        // sources need an extension word.
        if (d.cls == CLS_TWOOP || d.cls == CLS_ONEOP) begin
            d.src_ext = (as_m == 2'b01 && rs != 4'd3) || (as_m == 2'b11 && rs == 4'd0);
        end
        if (d.cls == CLS_TWOOP) begin
            d.dst_ext = w[7];
            // CMP and BIT only set flags, so memory destinations are not written.
            d.wb      = w[7] && (w[15:12] != 4'h9) && (w[15:12] != 4'hB);
        end
        if (d.cls == CLS_ONEOP) begin
            // w[9] set covers PUSH/CALL/RETI; the rest write back unless register mode.
            d.wb = w[9] || (as_m != 2'b00);
        end
        return d;
    endfunction

    step_e       step_q, step_d;
    logic [2:0]  cls_q, cls_d;
    logic [15:0] iw_q, iw_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        timeout_q, timeout_d;

    dec_t        dec_new;
    dec_t        dec_cur;
    logic        irq_take;
    logic        mem_step;

    always_ff @(posedge MCLK or negedge RST_n) begin
        if (!RST_n) begin
            step_q    <= ST_FETCH;
            cls_q     <= CLS_FETCH;
            iw_q      <= '0;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            step_q    <= step_d;
            cls_q     <= cls_d;
            iw_q      <= iw_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        dec_new   = decode(IW);
        dec_cur   = decode(iw_q);
        irq_take  = IRQ_EN && IRQ;
        mem_step  = (step_q != ST_FETCH) && (step_q != ST_EXEC);
        step_d    = step_q;
        cls_d     = cls_q;
        iw_d      = iw_q;
        wcnt_d    = '0;
        timeout_d = 1'b0;

        case (step_q)
            ST_FETCH: begin
                if (irq_take) begin
                    step_d = ST_IRQ_PC;
                end else if (IW_valid) begin
                    iw_d  = IW;
                    cls_d = dec_new.cls;
                    if (dec_new.src_ext)      step_d = ST_SRC_EXT;
                    else if (dec_new.dst_ext) step_d = ST_DST_EXT;
                    else                      step_d = ST_EXEC;
                end
            end
            ST_SRC_EXT: if (MEM_rdy) step_d = dec_cur.dst_ext ? ST_DST_EXT : ST_EXEC;
            ST_DST_EXT: if (MEM_rdy) step_d = ST_EXEC;
            ST_EXEC:    step_d = dec_cur.wb ? ST_WB : ST_FETCH;
            ST_WB:      if (MEM_rdy) step_d = ST_FETCH;
            ST_IRQ_PC:  if (MEM_rdy) step_d = ST_IRQ_SR;
            ST_IRQ_SR:  if (MEM_rdy) step_d = ST_IRQ_VEC;
            ST_IRQ_VEC: if (MEM_rdy) step_d = ST_FETCH;
            default:    step_d = ST_FETCH;
        endcase

        // Counter restarts whenever the step changes; only a stall keeps counting.
        if (mem_step && !MEM_rdy) begin
            if (wcnt_q == WD_LAST) begin
                step_d    = ST_FETCH;
                timeout_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 8'd1;
            end
        end

        if (step_d == ST_FETCH) cls_d = CLS_FETCH;
    end

    always_comb begin
        // RST_n gating keeps the combinational ack low while reset is held.
        IW_ack  = RST_n && (step_q == ST_FETCH) && IW_valid && !irq_take;
        CAR     = CAR_BITS'({cls_q, step_q});
        BUSY    = (step_q != ST_FETCH);
        ILLEGAL = (step_q == ST_EXEC) && (cls_q == CLS_ILLEGAL);
        TIMEOUT = timeout_q;
    end

endmodule

// File: tb/tb_car_sequencer.sv
module tb_car_sequencer;

    logic        MCLK = 1'b0;
    logic        RST_n;
    logic [15:0] IW;
    logic        IW_valid;
    logic        MEM_rdy;
    logic        IRQ;

    logic [5:0]  car  [3];
    logic        ack  [3];
    logic        busy [3];
    logic        ill  [3];
    logic        to   [3];

    always #5 MCLK = ~MCLK;

    car_sequencer #(.CAR_BITS(6), .IRQ_EN(1'b1), .MEM_WAIT_MAX(16)) dut_a (
        .MCLK(MCLK), .RST_n(RST_n), .IW(IW), .IW_valid(IW_valid), .IW_ack(ack[0]),
        .MEM_rdy(MEM_rdy), .IRQ(IRQ), .CAR(car[0]), .BUSY(busy[0]),
        .ILLEGAL(ill[0]), .TIMEOUT(to[0]));

    car_sequencer #(.CAR_BITS(6), .IRQ_EN(1'b0), .MEM_WAIT_MAX(16)) dut_b (
        .MCLK(MCLK), .RST_n(RST_n), .IW(IW), .IW_valid(IW_valid), .IW_ack(ack[1]),
        .MEM_rdy(MEM_rdy), .IRQ(IRQ), .CAR(car[1]), .BUSY(busy[1]),
        .ILLEGAL(ill[1]), .TIMEOUT(to[1]));

    car_sequencer #(.CAR_BITS(6), .IRQ_EN(1'b1), .MEM_WAIT_MAX(4)) dut_c (
        .MCLK(MCLK), .RST_n(RST_n), .IW(IW), .IW_valid(IW_valid), .IW_ack(ack[2]),
        .MEM_rdy(MEM_rdy), .IRQ(IRQ), .CAR(car[2]), .BUSY(busy[2]),
        .ILLEGAL(ill[2]), .TIMEOUT(to[2]));

    int checks = 0;
    int errors = 0;

    // Reference model: each instruction expands into a short list of CAR codes;
    // the model walks that list, stalling on memory steps.
    int irq_en [3] = '{1, 0, 1};
    int wmax   [3] = '{16, 16, 4};
    int pl     [3][4];
    int plen   [3];
    int ppos   [3];
    int wt     [3];
    bit to_exp [3];

    logic [15:0] iw_tab [8] = '{16'h4000, 16'h4292, 16'h9292, 16'h1213,
                                16'h3C00, 16'h0000, 16'h1380, 16'h12B0};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_car(input int i);
        return (ppos[i] < plen[i]) ? pl[i][ppos[i]] : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            plen[i] = 0; ppos[i] = 0; wt[i] = 0; to_exp[i] = 1'b0;
        end
    endtask

    task automatic build(input int i, input logic [15:0] w);
        int cls, as_m, rs;
        bit src, dst, wb;
        as_m = int'(w[5:4]);
        if (w[15:13] == 3'b001)                              cls = 2;
        else if (int'(w[15:12]) >= 4)                        cls = 3;
        else if (w[15:10] == 6'b000100 && w[9:7] != 3'b111)  cls = 1;
        else                                                 cls = 7;
        rs  = (cls == 3) ? int'(w[11:8]) : int'(w[3:0]);
        src = (cls == 1 || cls == 3) && ((as_m == 1 && rs != 3) || (as_m == 3 && rs == 0));
        dst = (cls == 3) && w[7];
        wb  = 1'b0;
        if (cls == 3) wb = w[7] && int'(w[15:12]) != 9 && int'(w[15:12]) != 11;
        if (cls == 1) wb = (int'(w[9:7]) >= 4) || (as_m != 0);
        plen[i] = 0; ppos[i] = 0;
        if (src) begin pl[i][plen[i]] = cls * 8 + 1; plen[i]++; end
        if (dst) begin pl[i][plen[i]] = cls * 8 + 2; plen[i]++; end
        pl[i][plen[i]] = cls * 8 + 3; plen[i]++;
        if (wb)  begin pl[i][plen[i]] = cls * 8 + 4; plen[i]++; end
    endtask

    task automatic model_edge(input int i);
        to_exp[i] = 1'b0;
        if (ppos[i] >= plen[i]) begin
            wt[i] = 0;
            if (irq_en[i] != 0 && IRQ) begin
                pl[i][0] = 5; pl[i][1] = 6; pl[i][2] = 7; plen[i] = 3; ppos[i] = 0;
            end else if (IW_valid) begin
                build(i, IW);
            end
        end else if ((pl[i][ppos[i]] % 8) == 3 || MEM_rdy) begin
            ppos[i]++;
            wt[i] = 0;
        end else begin
            wt[i]++;
            if (wt[i] == wmax[i]) begin
                ppos[i] = plen[i]; wt[i] = 0; to_exp[i] = 1'b1;
            end
        end
    endtask

    task automatic chk_pre();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ack[%0d]", i), 16'(ack[i]),
                16'(RST_n && ppos[i] >= plen[i] && IW_valid && !(irq_en[i] != 0 && IRQ)));
        end
    endtask

    task automatic chk_post();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("car[%0d]", i),     16'(car[i]),  16'(exp_car(i)));
            chk($sformatf("busy[%0d]", i),    16'(busy[i]), 16'(ppos[i] < plen[i]));
            chk($sformatf("illegal[%0d]", i), 16'(ill[i]),  16'(exp_car(i) == 59));
            chk($sformatf("timeout[%0d]", i), 16'(to[i]),   16'(to_exp[i]));
        end
    endtask

    task automatic cycle(input logic [15:0] w, input logic v, input logic r, input logic q);
        @(negedge MCLK);
        IW = w; IW_valid = v; MEM_rdy = r; IRQ = q;
        #1 chk_pre();
        @(posedge MCLK);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1 chk_post();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(16'h0000, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int burst;
        logic [15:0] w;
        logic v, r, q;

        IW = '0; IW_valid = 1'b1; MEM_rdy = 1'b1; IRQ = 1'b0; RST_n = 1'b0;
        model_reset();
        #2 chk_post();
        chk_pre();
        @(negedge MCLK) RST_n = 1'b1; IW_valid = 1'b0;

        // MOV R0,R0: 0, 27, 0
        cycle(16'h4000, 1'b1, 1'b1, 1'b0);
        chk("mov_exec_car", 16'(car[0]), 16'd27);
        idle(1);

        // MOV &x,&y with memory ready, then with three stalls in SRC_EXT
        cycle(16'h4292, 1'b1, 1'b1, 1'b0);
        chk("mov_abs_src", 16'(car[0]), 16'd25);
        idle(4);
        cycle(16'h4292, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("stall_hold", 16'(car[0]), 16'd25);
        idle(4);

        // CMP (no WB), PUSH #1, JMP
        cycle(16'h9292, 1'b1, 1'b1, 1'b0);
        idle(3);
        cycle(16'h1213, 1'b1, 1'b1, 1'b0);
        chk("push_exec", 16'(car[0]), 16'd11);
        idle(2);
        cycle(16'h3C00, 1'b1, 1'b1, 1'b0);
        chk("jmp_exec", 16'(car[0]), 16'd19);
        idle(1);

        // Illegal opcodes
        cycle(16'h0000, 1'b1, 1'b1, 1'b0);
        chk("illegal_0000", 16'(ill[0]), 16'd1);
        idle(1);
        cycle(16'h1380, 1'b1, 1'b1, 1'b0);
        chk("illegal_1380", 16'(car[0]), 16'd59);
        idle(1);

        // IRQ beats IW_valid; the IRQ-disabled instance fetches normally
        cycle(16'h4000, 1'b1, 1'b1, 1'b1);
        chk("irq_pc", 16'(car[0]), 16'd5);
        chk("noirq_exec", 16'(car[1]), 16'd27);
        idle(4);

        // Watchdog: short-limit instance aborts after 4 stalls, default after 16
        cycle(16'h4292, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle(16'h0000, 1'b0, 1'b0, 1'b0);
        chk("wd4_timeout", 16'(to[2]), 16'd1);
        repeat (14) cycle(16'h0000, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Reset while in DST_EXT
        cycle(16'h4292, 1'b1, 1'b1, 1'b0);
        idle(1);
        chk("pre_reset_dst", 16'(car[0]), 16'd26);
        @(negedge MCLK);
        RST_n = 1'b0; IW_valid = 1'b1;
        #1 model_reset();
        chk("async_reset_car", 16'(car[0]), 16'd0);
        chk_post();
        chk_pre();
        @(negedge MCLK) RST_n = 1'b1; IW_valid = 1'b0;

        // Randomized traffic, with occasional long stall bursts
        burst = 0;
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) w = iw_tab[$urandom_range(0, 7)];
            else                           w = 16'($urandom);
            v = ($urandom_range(0, 3) != 0);
            q = ($urandom_range(0, 9) == 0);
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = 20;
            if (burst > 0) begin
                r = 1'b0;
                burst--;
            end else begin
                r = ($urandom_range(0, 4) != 0);
            end
            cycle(w, v, r, q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
